figure_tx: RTL and testbench
============================

// Module: figure_tx
// PURPOSE
// - Transmit-side counterpart of the receiver's dot-matrix display path. Serialises the 3-bit
//   driving command (figure) into a pulse-width-coded frame on one wire for the RF/IR module.
// - The remote receiver decodes this frame back into `figure` and drives the 8x8 display.
// - Each request is sent REPEAT times for robustness; the block then reports completion.
// PARAMETERS
// - ADDR      8'hA5  link address, sent MSB first ahead of the command
// - ADDR_W    8      address width in bits
// - START_HI  8      start-symbol high time, in clk_1k ticks
// - START_LO  4      start-symbol low time, in ticks
// - GAP       10     low gap after each frame, in ticks
// - REPEAT    3      frames per request (>=1)
// PORTS
// - clk_1k  in   1  1 kHz system tick; all state updates on its rising edge
// - rst     in   1  asynchronous, active-high reset
// - figure  in   3  command: 0 left, 1 right, 2 straight, 3 stop, 4 reverse (5-7 sent unchanged)
// - send    in   1  request; sampled only while idle
// - tx      out  1  serial line; idle low
// - busy    out  1  high from the cycle after acceptance until the last gap ends
// - done    out  1  one-cycle pulse on the first idle cycle after a request completes
// BEHAVIOUR
// - Reset (async): tx=0, busy=0, done=0, state IDLE, all counters 0.
//   - Mid-frame reset abandons the frame; tx drops in the same cycle.
// - Accept: at an edge where state==IDLE and send==1:
//   - Latch payload = {ADDR, figure, par}; par = ^{ADDR, figure} (even parity over all ones).
//   - Go to START_H. busy=1 and tx=1 take effect from that edge.
// - send while busy is ignored; figure changes while busy do not alter the latched payload.
// - FSM states and transitions:
//   - IDLE -> START_H on accept.
//   - START_H (tx=1, START_HI ticks) -> START_L (tx=0, START_LO ticks) -> BITS.
//   - BITS: ADDR_W+4 bits sent MSB first, 3 ticks per bit:
//     - bit 1 = H,H,L; bit 0 = H,L,L.
//   - After the last bit -> GAP (tx=0, GAP ticks).
//   - From GAP: if the repeat count is below REPEAT, go to START_H with the same payload;
//     otherwise go to IDLE.
// - Frame length F = START_HI+START_LO+3*(ADDR_W+4)+GAP ticks (defaults: 8+4+36+10 = 58).
// - busy is high for exactly REPEAT*F cycles (defaults: 174).
// - done=1 and busy=0 on the first IDLE cycle. A send sampled in that cycle is accepted,
//   so a held send gives back-to-back requests with exactly one idle cycle between them.
// - Counters:
//   - Tick counter wide enough for max(START_HI, START_LO, GAP, 3).
//   - Bit index width clog2(ADDR_W+4); repeat count width clog2(REPEAT+1).
//   - No counter wraps in normal operation.
// - tx is driven from a register (no combinational glitches).
// STRUCTURE
// - Shared header figure_defs.vh holds:
//   - Figure codes: FIG_LEFT=0, FIG_RIGHT=1, FIG_STRAIGHT=2, FIG_STOP=3, FIG_REVERSE=4.
//   - FSM state encodings.
//   - Bit-symbol constants: 3 ticks per bit; high ticks 2 for '1', 1 for '0'.
// - The receiver-side decoder includes the same header.
// - One sub-module: pw_bit_enc.
//   - Inputs: start, bit. Outputs: tx_bit, bit_done.
//   - Produces one 3-tick symbol; the top level owns the start/gap/repeat FSM.
// TESTING
// - Reset: assert rst mid-simulation -> tx=0, busy=0, done=0 in the same cycle.
// - figure=3, 1-cycle send: payload 1010_0101_011_0 (par=0).
//   - tx shows 8H, 4L, 12 symbols, 10L; repeated 3 times.
//   - busy high 174 cycles; done pulses on cycle 175.
// - figure=1: payload ends 001_1 (par=1) -> last symbol H,H,L in every repeat.
// - figure changes 1->4 and send re-pulses during busy -> all 3 frames still carry 001;
//   done pulses exactly once.
// - send held high with figure=2 -> busy low for exactly 1 cycle (done=1) between consecutive
//   174-cycle transmissions.
// - rst during the 5th bit of frame 2 -> tx=0 immediately.
//   - After release: idle, no done pulse; next send starts a fresh 3-frame request.

Source files
------------

// File: rtl/figure_tx_pkg.sv
// Shared definitions for the figure link: command codes, FSM encodings and
// the pulse-width bit-symbol shape used by both transmitter and receiver.
package figure_tx_pkg;

  localparam logic [2:0] FIG_LEFT     = 3'd0;
  localparam logic [2:0] FIG_RIGHT    = 3'd1;
  localparam logic [2:0] FIG_STRAIGHT = 3'd2;
  localparam logic [2:0] FIG_STOP     = 3'd3;
  localparam logic [2:0] FIG_REVERSE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START_H = 3'd1,
    ST_START_L = 3'd2,
    ST_BITS    = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  // Every bit is BIT_TICKS long and starts high; a '1' stays high longer.
  localparam int BIT_TICKS = 3;
  localparam int HI_ONE    = 2;
  localparam int HI_ZERO   = 1;
  localparam int PH_W      = $clog2(BIT_TICKS);

  function automatic logic [PH_W-1:0] sym_hi(input logic b);
    return b ? PH_W'(HI_ONE) : PH_W'(HI_ZERO);
  endfunction

endpackage

// File: rtl/figure_tx_pw_bit_enc.sv
// One pulse-width bit symbol. Outputs look one tick ahead so the caller can
// register the line level; bit_done marks the symbol's final tick.
module pw_bit_enc
  import figure_tx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_val,
  output logic tx_bit,
  output logic bit_done
);

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(BIT_TICKS - 1);

  logic [PH_W-1:0] ph;
  logic [PH_W-1:0] hi_q;
  logic            active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph     <= '0;
      hi_q   <= '0;
      active <= 1'b0;
    end else if (start) begin
      ph     <= '0;
      hi_q   <= sym_hi(bit_val);
      active <= 1'b1;
    end else if (active) begin
      if (ph == LAST_PH) begin
        active <= 1'b0;
      end else begin
        ph <= ph + 1'b1;
      end
    end
  end

  // tx_bit is the level of the tick that follows the next clock edge.
  always_comb begin
    bit_done = active && (ph == LAST_PH);
    if (start) begin
      tx_bit = (sym_hi(bit_val) != '0);
    end else begin
      tx_bit = active && (ph != LAST_PH) && ((ph + 1'b1) < hi_q);
    end
  end

endmodule

// File: rtl/figure_tx.sv
// Figure command transmitter: start symbol, address+command+parity as
// pulse-width bits, trailing gap, repeated REPEAT times per request.
module figure_tx
  import figure_tx_pkg::*;
#(
  parameter logic [7:0] ADDR     = 8'hA5,
  parameter int         ADDR_W   = 8,
  parameter int         START_HI = 8,
  parameter int         START_LO = 4,
  parameter int         GAP      = 10,
  parameter int         REPEAT   = 3
) (
  input  logic       clk_1k,
  input  logic       rst,
  input  logic [2:0] figure,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output state_t     state
);

  localparam int PAY_W    = ADDR_W + 4;
  localparam int BIDX_W   = $clog2(PAY_W);
  localparam int REP_W    = $clog2(REPEAT + 1);
  localparam int MAX_A    = (START_HI > START_LO) ? START_HI : START_LO;
  localparam int MAX_B    = (MAX_A > GAP) ? MAX_A : GAP;
  localparam int TICK_MAX = (MAX_B > BIT_TICKS) ? MAX_B : BIT_TICKS;
  localparam int CNT_W    = $clog2(TICK_MAX + 1);

  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(PAY_W - 1);

  state_t            state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [BIDX_W-1:0] bit_idx, bit_idx_n;
  logic [REP_W-1:0]  rep, rep_n;
  logic [PAY_W-1:0]  payload;
  logic              busy_n, done_n, tx_n;
  logic              accept;
  logic              enc_start, enc_bit, enc_tx, enc_done;

  assign accept = (state == ST_IDLE) && send;

  pw_bit_enc u_enc (
    .clk      (clk_1k),
    .rst      (rst),
    .start    (enc_start),
    .bit_val  (enc_bit),
    .tx_bit   (enc_tx),
    .bit_done (enc_done)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    rep_n     = rep;
    busy_n    = busy;
    done_n    = 1'b0;
    enc_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (send) begin
          state_n = ST_START_H;
          cnt_n   = '0;
          rep_n   = '0;
          busy_n  = 1'b1;
        end
      end
      ST_START_H: begin
        if (cnt == CNT_W'(START_HI - 1)) begin
          state_n = ST_START_L;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_START_L: begin
        if (cnt == CNT_W'(START_LO - 1)) begin
          state_n   = ST_BITS;
          cnt_n     = '0;
          bit_idx_n = '0;
          enc_start = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_BITS: begin
        if (enc_done) begin
          if (bit_idx == LAST_IDX) begin
            state_n = ST_GAP;
            cnt_n   = '0;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            enc_start = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (cnt == CNT_W'(GAP - 1)) begin
          cnt_n = '0;
          if (rep == REP_W'(REPEAT - 1)) begin
            state_n = ST_IDLE;
            rep_n   = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = ST_START_H;
            rep_n   = rep + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
    endcase
    // MSB first: bit_idx 0 carries payload[PAY_W-1].
    enc_bit = payload[LAST_IDX - bit_idx_n];
  end

  // Line level for the coming tick, taken from where the FSM is heading.
  always_comb begin
    tx_n = (state_n == ST_START_H) || ((state_n == ST_BITS) && enc_tx);
  end

  always_ff @(posedge clk_1k or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      rep     <= '0;
      payload <= '0;
      tx      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      rep     <= rep_n;
      tx      <= tx_n;
      busy    <= busy_n;
      done    <= done_n;
      if (accept) begin
        payload <= {ADDR, figure, ^{ADDR, figure}};
      end
    end
  end

endmodule

// File: tb/tb_figure_tx.sv
// Directed bench for figure_tx: full tx waveform per request against a
// queue of expected line levels, plus busy/done/reset behaviour.
module tb_figure_tx;
  import figure_tx_pkg::*;

  logic       clk_1k = 1'b0;
  logic       rst;
  logic [2:0] figure;
  logic       send;
  logic       tx;
  logic       busy;
  logic       done;
  state_t     state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [0:0] exp_q[$];

  // Hand-computed payloads {8'hA5, figure, even parity}
  localparam logic [11:0] PAY_STOP     = 12'b1010_0101_011_0;
  localparam logic [11:0] PAY_RIGHT    = 12'b1010_0101_001_1;
  localparam logic [11:0] PAY_STRAIGHT = 12'b1010_0101_010_1;

  figure_tx dut (
    .clk_1k (clk_1k),
    .rst    (rst),
    .figure (figure),
    .send   (send),
    .tx     (tx),
    .busy   (busy),
    .done   (done),
    .state  (state)
  );

  always #5 clk_1k = ~clk_1k;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_1k);
    #1;
  endtask

  // Three frames: 8 high, 4 low, 12 symbols (H,b,L), 10 low.
  task automatic load_exp(input logic [11:0] pay);
    exp_q.delete();
    for (int r = 0; r < 3; r++) begin
      for (int t = 0; t < 8; t++) exp_q.push_back(1'b1);
      for (int t = 0; t < 4; t++) exp_q.push_back(1'b0);
      for (int k = 11; k >= 0; k--) begin
        exp_q.push_back(1'b1);
        exp_q.push_back(pay[k]);
        exp_q.push_back(1'b0);
      end
      for (int t = 0; t < 10; t++) exp_q.push_back(1'b0);
    end
  endtask

  // Call from an idle cycle; the next edge accepts. Ends in the done cycle
  // unless aborted by reset at busy cycle abort_at.
  task automatic run_req(input logic [11:0] pay, input logic [2:0] fig,
                         input bit hold, input bit disturb, input int abort_at);
    load_exp(pay);
    figure = fig;
    send   = 1'b1;
    for (int i = 0; i < 174; i++) begin
      tick();
      if (!hold && i == 0) send = 1'b0;
      if (disturb && i == 20) figure = FIG_REVERSE;
      if (disturb && i == 50) send = 1'b1;
      if (disturb && i == 51) send = 1'b0;
      check("tx", 32'(tx), 32'(exp_q.pop_front()));
      check("busy_high", 32'(busy), 32'd1);
      check("done_low_while_busy", 32'(done), 32'd0);
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_tx", 32'(tx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(state), 32'(ST_IDLE));
        return;
      end
    end
    tick();
    check("end_busy", 32'(busy), 32'd0);
    check("end_done", 32'(done), 32'd1);
    check("end_tx", 32'(tx), 32'd0);
    check("end_state", 32'(state), 32'(ST_IDLE));
  endtask

  initial begin
    rst    = 1'b1;
    send   = 1'b0;
    figure = FIG_LEFT;
    tick();
    tick();
    check("reset_tx", 32'(tx), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_state", 32'(state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();
    check("idle_tx", 32'(tx), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Stop command, single-cycle send
    run_req(PAY_STOP, FIG_STOP, 1'b0, 1'b0, -1);
    tick();
    check("stop_done_once", 32'(done), 32'd0);

    // Right command: parity 1, last symbol H,H,L
    run_req(PAY_RIGHT, FIG_RIGHT, 1'b0, 1'b0, -1);
    tick();
    check("right_done_once", 32'(done), 32'd0);

    // Figure change and send re-pulse while busy are ignored
    run_req(PAY_RIGHT, FIG_RIGHT, 1'b0, 1'b1, -1);
    tick();
    check("dist_done_once", 32'(done), 32'd0);
    check("dist_no_retrigger", 32'(busy), 32'd0);
    tick();
    check("dist_still_idle", 32'(busy), 32'd0);

    // Held send: back-to-back requests with one idle cycle between
    run_req(PAY_STRAIGHT, FIG_STRAIGHT, 1'b1, 1'b0, -1);
    run_req(PAY_STRAIGHT, FIG_STRAIGHT, 1'b1, 1'b0, -1);
    send = 1'b0;
    tick();
    check("hold_release_busy", 32'(busy), 32'd0);
    check("hold_release_done", 32'(done), 32'd0);

    // Reset during tick 0 of bit 5 in frame 2 (busy cycle 82)
    run_req(PAY_STOP, FIG_STOP, 1'b0, 1'b0, 82);
    tick();
    check("rst_hold_tx", 32'(tx), 32'd0);
    check("rst_hold_busy", 32'(busy), 32'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_tx", 32'(tx), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_done", 32'(done), 32'd0);
    end
    run_req(PAY_STOP, FIG_STOP, 1'b0, 1'b0, -1);
    tick();
    check("fresh_done_once", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
